// File: rtl/board_io_ctrl.sv
// Memory-mapped board I/O: synchronised switches, debounced push-buttons with sticky
// press events (write-1-to-clear), registered LED bank and a level interrupt.
module board_io_ctrl #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned N_BTN      = 1,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic [N_BTN-1:0]  btn,
    output logic [DATA_W-1:0] led,
    input  logic [1:0]        addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              irq
);

    localparam int unsigned CNT_W = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam logic [1:0] ADDR_SW  = 2'd0;
    localparam logic [1:0] ADDR_LED = 2'd1;
    localparam logic [1:0] ADDR_LVL = 2'd2;
    localparam logic [1:0] ADDR_EVT = 2'd3;

    logic [DATA_W-1:0] sw_meta_q, sw_s_q;
    logic [N_BTN-1:0]  btn_meta_q, btn_s_q;
    logic [N_BTN-1:0]  stable_q, stable_d;
    logic [N_BTN-1:0]  evt_q, evt_d;
    logic [N_BTN-1:0]  evt_clr, rise;
    logic [CNT_W-1:0]  cnt_q [N_BTN];
    logic [CNT_W-1:0]  cnt_d [N_BTN];
    logic [DATA_W-1:0] lvl_ext, evt_ext, rd_mux;

    // Counter tracks consecutive edges where the synchronised input disagrees with the
    // accepted state; the DEB_CYCLES-th disagreeing edge flips the state.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(N_BTN); i++) begin
            cnt_d[i] = '0;
            if (btn_s_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        rise    = stable_d & ~stable_q;
        evt_clr = (wr_en && (addr == ADDR_EVT)) ? wdata[N_BTN-1:0] : '0;
        // A new press on the same edge as its clear keeps the flag set.
        evt_d   = (evt_q & ~evt_clr) | rise;
    end

    always_comb begin
        lvl_ext = '0;
        lvl_ext[N_BTN-1:0] = stable_q;
        evt_ext = '0;
        evt_ext[N_BTN-1:0] = evt_q;
        unique case (addr)
            ADDR_SW:  rd_mux = sw_s_q;
            ADDR_LED: rd_mux = led;
            ADDR_LVL: rd_mux = lvl_ext;
            ADDR_EVT: rd_mux = evt_ext;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
            btn_meta_q <= '0;
            btn_s_q    <= '0;
            stable_q   <= '0;
            evt_q      <= '0;
            led        <= '0;
            rdata      <= '0;
            irq        <= 1'b0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sw_meta_q  <= sw;
            sw_s_q     <= sw_meta_q;
            btn_meta_q <= btn;
            btn_s_q    <= btn_meta_q;
            stable_q   <= stable_d;
            evt_q      <= evt_d;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (wr_en && (addr == ADDR_LED)) begin
                led <= wdata;
            end
            if (rd_en) begin
                rdata <= rd_mux;
            end
            irq <= |evt_q;
        end
    end

endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
Parametrised memory-mapped I/O controller between the board pins (switches, push-buttons, LEDs) and the simple machine's data bus. Adds to the fixed 8-bit sw/Led/btnS board top a configurable data width and button count, per-button synchroniser plus debouncer, sticky press-event flags with write-1-to-clear, and a level interrupt. The CPU reads switches and buttons and drives the LEDs through four registers.

Parameters:
DATA_W, 8, width of switch bank, LED bank and bus data
N_BTN, 1, number of push-buttons (1..DATA_W)
DEB_CYCLES, 4, consecutive differing cycles needed to accept a button change (>=1; small for simulation, large on board)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
sw  in  DATA_W  raw asynchronous switch inputs
btn  in  N_BTN  raw asynchronous button inputs, active-high
led  out  DATA_W  LED drive, registered
addr  in  2  register address
wr_en  in  1  write strobe, one cycle
rd_en  in  1  read strobe, one cycle
wdata  in  DATA_W  write data
rdata  out  DATA_W  read data, registered
irq  out  1  high while any event flag is set

Behaviour:
- Reset (rst_n low at a clk edge): led=0, rdata=0, irq=0; all synchroniser flops, debounce counters, stable button states and event flags = 0. Reset mid-debounce discards the count.
- Register map: 0 SW (RO) = synchronised sw; 1 LED (RW) = led; 2 BTN_LVL (RO) = debounced stable states, zero-extended; 3 BTN_EVT (R/W1C) = sticky press flags, zero-extended.
- Synchronisers: 2-flop on every sw and btn bit. sw change visible in SW register 2 edges after it is applied.
- Debounce per button, counter sized for 0..DEB_CYCLES: on each edge, if btn_s == stable, count=0; otherwise count+1. When btn_s has differed from stable on DEB_CYCLES consecutive edges, stable flips on that edge and count clears. Glitch shorter than DEB_CYCLES: no change. Both press and release are debounced.
- Latency: btn held high from before edge 0 -> stable=1 after edge DEB_CYCLES+1.
- Event: on the edge where stable goes 0->1, evt[i] is set. Release sets nothing.
- W1C: write to addr 3 clears evt bits where wdata=1; bits N_BTN and above are ignored. Set and clear of the same bit on the same edge: set wins (flag stays 1).
- Write to addr 1: led <= wdata on that edge. Writes to addr 0 and 2 are ignored.
- Read: rd_en at edge k -> rdata holds the addressed register value sampled before edge k, valid from edge k until the next rd_en. Without rd_en, rdata holds its value.
- Simultaneous rd_en and wr_en: the read returns the pre-write value. For addr 3, the read returns the flags before the clear.
- irq = registered OR of evt flags. It rises one edge after the flag sets and falls one edge after the last flag clears.

Test Plan:
- Reset: drive sw=8'hFF, btn=1, rst_n=0 for 3 cycles -> led=0, rdata=0, irq=0; read addr 2 and 3 after release -> 0, and BTN_LVL becomes 1 only after 2+DEB_CYCLES edges.
- Switch read: sw=8'd1, 8'd2, 8'd3, 8'd4 held for 5 cycles each; read addr 0 on the last cycle of each hold -> rdata=1, 2, 3, 4. A read issued 1 cycle after a change returns the old value.
- LED write: write 8'hA5 to addr 1 -> led=8'hA5 after the edge, and reading addr 1 returns 8'hA5. Write to addr 0 -> SW register and led unchanged.
- Debounce (DEB_CYCLES=4): btn pulse 3 cycles -> BTN_LVL=0 and BTN_EVT=0. btn held for 20 cycles -> BTN_LVL=1 after edge 5, BTN_EVT=1, irq=1 one edge later. Release -> BTN_LVL=0 after 6 edges and BTN_EVT stays 1.
- W1C race: with evt[0]=1, write 1 to addr 3 -> evt clears and irq drops one edge later. Repeat with the write on the same edge as a new debounced press -> evt stays 1. Simultaneous read of addr 3 returns the pre-clear value.
- Parametrisation: DATA_W=4, N_BTN=3, two buttons pressed on overlapping windows -> BTN_EVT=3'b011 and irq=1. Clear bit 0 -> BTN_EVT=3'b010 and irq stays 1.
